// File: rtl/video_timing_pattern_gen.sv
// rtl/video_timing_pattern_gen.sv - parametrised video timing generator with runtime-selectable test patterns
module video_timing_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int CHECK_LOG2 = 3,
    parameter int BOX_SIZE   = 16,
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW        = $clog2(H_TOTAL),
    localparam int VW        = $clog2(V_TOTAL)
) (
    input  logic          clk100M_in,
    input  logic          rstn_in,
    input  logic          pix_ce_in,
    input  logic [1:0]    mode_in,
    input  logic [23:0]   color_in,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic          de_out,
    output logic [23:0]   rgb_out,
    output logic [HW-1:0] x_out,
    output logic [VW-1:0] y_out,
    output logic          frame_start_out
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [HW-1:0] box_x;
    logic [1:0]    mode_q;
    logic [23:0]   color_q;
    logic [3:0]    bar_idx;
    logic [15:0]   bar_px;

    logic          first_px;
    logic          h_last;
    logic          v_last;
    logic          de_d;
    logic          hs_act;
    logic          vs_act;
    logic          in_box;
    logic [1:0]    eff_mode;
    logic [23:0]   eff_color;
    logic [23:0]   bar_rgb;
    logic [23:0]   pat_rgb;

    always_comb begin
        first_px  = (h_cnt == '0) && (v_cnt == '0);
        h_last    = int'(h_cnt) == H_TOTAL - 1;
        v_last    = int'(v_cnt) == V_TOTAL - 1;
        de_d      = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
        hs_act    = (int'(h_cnt) >= H_ACTIVE + H_FP) && (int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
        vs_act    = (int'(v_cnt) >= V_ACTIVE + V_FP) && (int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);
        // The first pixel of a frame already uses the newly sampled mode/colour.
        eff_mode  = first_px ? mode_in  : mode_q;
        eff_color = first_px ? color_in : color_q;
        in_box    = (int'(h_cnt) >= int'(box_x)) && (int'(h_cnt) < int'(box_x) + BOX_SIZE)
                    && (int'(v_cnt) < BOX_SIZE);

        case (bar_idx)
            4'd0:    bar_rgb = 24'hFFFFFF;
            4'd1:    bar_rgb = 24'hFFFF00;
            4'd2:    bar_rgb = 24'h00FFFF;
            4'd3:    bar_rgb = 24'h00FF00;
            4'd4:    bar_rgb = 24'hFF00FF;
            4'd5:    bar_rgb = 24'hFF0000;
            4'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase

        case (eff_mode)
            2'd0:    pat_rgb = eff_color;
            2'd1:    pat_rgb = bar_rgb;
            2'd2:    pat_rgb = (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) ? 24'h000000 : 24'hFFFFFF;
            default: pat_rgb = in_box ? eff_color : 24'h000000;
        endcase
    end

    always_ff @(posedge clk100M_in) begin
        if (!rstn_in) begin
            h_cnt           <= '0;
            v_cnt           <= '0;
            box_x           <= '0;
            mode_q          <= '0;
            color_q         <= '0;
            bar_idx         <= '0;
            bar_px          <= '0;
            hsync_out       <= ~HS_POL;
            vsync_out       <= ~VS_POL;
            de_out          <= 1'b0;
            rgb_out         <= '0;
            x_out           <= '0;
            y_out           <= '0;
            frame_start_out <= 1'b0;
        end else begin
            frame_start_out <= 1'b0;
            if (pix_ce_in) begin
                hsync_out       <= hs_act ? HS_POL : ~HS_POL;
                vsync_out       <= vs_act ? VS_POL : ~VS_POL;
                de_out          <= de_d;
                rgb_out         <= de_d ? pat_rgb : 24'h000000;
                x_out           <= h_cnt;
                y_out           <= v_cnt;
                frame_start_out <= first_px;

                if (first_px) begin
                    mode_q  <= mode_in;
                    color_q <= color_in;
                end

                // Bar index tracks x / BAR_W incrementally, saturating at 8 for remainder pixels.
                if (h_last) begin
                    bar_idx <= '0;
                    bar_px  <= '0;
                end else if (bar_px == 16'(BAR_W - 1)) begin
                    bar_px <= '0;
                    if (bar_idx != 4'd8)
                        bar_idx <= bar_idx + 4'd1;
                end else begin
                    bar_px <= bar_px + 16'd1;
                end

                if (h_last) begin
                    h_cnt <= '0;
                    if (v_last) begin
                        v_cnt <= '0;
                        // Box position for the next frame is settled as the current one ends.
                        if (int'(box_x) + 1 + BOX_SIZE > H_ACTIVE)
                            box_x <= '0;
                        else
                            box_x <= box_x + 1'b1;
                    end else begin
                        v_cnt <= v_cnt + 1'b1;
                    end
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// tb/tb_video_timing_pattern_gen.sv - self-checking bench for video_timing_pattern_gen
module tb_video_timing_pattern_gen;

    localparam int HT = 24;
    localparam int VT = 7;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ce_lvl;
    logic        toggle_ce;
    logic        tog = 1'b0;
    logic        ce;
    logic [1:0]  mode;
    logic [23:0] color;
    logic        hs, vs, de, fs;
    logic [23:0] rgb;
    logic [4:0]  xo;
    logic [2:0]  yo;

    int n_chk  = 0;
    int n_fail = 0;

    assign ce = toggle_ce ? tog : ce_lvl;

    video_timing_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CHECK_LOG2(1), .BOX_SIZE(4)
    ) dut (
        .clk100M_in(clk), .rstn_in(rstn), .pix_ce_in(ce),
        .mode_in(mode), .color_in(color),
        .hsync_out(hs), .vsync_out(vs), .de_out(de), .rgb_out(rgb),
        .x_out(xo), .y_out(yo), .frame_start_out(fs)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (toggle_ce) tog = ~tog; else tog = 1'b1;

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    int          pos, frames, m_box;
    logic [1:0]  m_mode;
    logic [23:0] m_color;
    logic        e_hs, e_vs, e_de, e_fs;
    logic [23:0] e_rgb;
    logic [4:0]  e_x;
    logic [2:0]  e_y;
    bit          mvalid = 1'b0;

    function automatic logic [23:0] pattern(int px, int py);
        logic [23:0] c;
        case (m_mode)
            2'd0:    c = m_color;
            2'd1:    c = (px < 16) ? bars[px / 2] : 24'h0;
            2'd2:    c = ((((px / 2) + (py / 2)) % 2) == 0) ? 24'hFFFFFF : 24'h0;
            default: c = (px >= m_box && px < m_box + 4 && py < 4) ? m_color : 24'h0;
        endcase
        return c;
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            pos = 0; frames = 0; m_box = 0; m_mode = 0; m_color = 0;
            e_hs = 1; e_vs = 1; e_de = 0; e_rgb = 0; e_x = 0; e_y = 0; e_fs = 0;
            mvalid = 1'b1;
        end else if (ce) begin
            int px, py;
            px = pos % HT;
            py = pos / HT;
            if (pos == 0) begin
                m_mode  = mode;
                m_color = color;
                m_box   = frames % 13;
                frames++;
            end
            e_de  = (px < 16) && (py < 4);
            e_hs  = !(px >= 18 && px < 21);
            e_vs  = (py != 5);
            e_rgb = e_de ? pattern(px, py) : 24'h0;
            e_x   = 5'(px);
            e_y   = 3'(py);
            e_fs  = (pos == 0);
            pos   = (pos + 1) % FRAME;
        end else begin
            e_fs = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            n_chk++;
            if ({hs, vs, de, rgb, xo, yo, fs} !== {e_hs, e_vs, e_de, e_rgb, e_x, e_y, e_fs}) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t got hs=%b vs=%b de=%b rgb=%h x=%0d y=%0d fs=%b want hs=%b vs=%b de=%b rgb=%h x=%0d y=%0d fs=%b",
                         $time, hs, vs, de, rgb, xo, yo, fs, e_hs, e_vs, e_de, e_rgb, e_x, e_y, e_fs);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_fs();
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (fs) return;
        end
        chk("wait_fs_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_pixel(input int px, input int py);
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (int'(xo) == px && int'(yo) == py) return;
        end
        chk("wait_pixel_timeout", 32'd1, 32'd0);
    endtask

    task automatic fs_period(input string nm, input int exp);
        int c = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            c++;
            if (fs) break;
        end
        chk(nm, 32'(c), 32'(exp));
    endtask

    initial begin
        rstn = 1'b0; ce_lvl = 1'b1; toggle_ce = 1'b0; mode = 2'd0; color = 24'h00FF00;
        @(negedge clk);
        @(negedge clk);
        chk("rst_sync", {30'd0, hs, vs}, 32'd3);
        chk("rst_de_rgb", {7'd0, de, rgb}, 32'd0);
        chk("rst_xy_fs", {23'd0, xo, yo, fs}, 32'd0);
        rstn = 1'b1;

        // Constant ce: timing and sync windows
        @(negedge clk);
        chk("first_fs", {23'd0, xo, yo, fs}, 32'd1);
        chk("first_rgb", 32'(rgb), 32'h00FF00);
        fs_period("fs_period_full", 168);
        wait_pixel(17, 0); chk("hs_17", 32'(hs), 32'd1);
        wait_pixel(18, 0); chk("hs_18", 32'(hs), 32'd0);
        wait_pixel(20, 0); chk("hs_20", 32'(hs), 32'd0);
        wait_pixel(21, 0); chk("hs_21", 32'(hs), 32'd1);
        wait_pixel(23, 4); chk("vs_line4", 32'(vs), 32'd1);
        wait_pixel(0, 5);  chk("vs_line5_start", 32'(vs), 32'd0);
        wait_pixel(23, 5); chk("vs_line5_end", 32'(vs), 32'd0);
        wait_pixel(0, 6);  chk("vs_line6", 32'(vs), 32'd1);

        // Half-rate ce
        toggle_ce = 1'b1;
        wait_fs();
        fs_period("fs_period_half", 336);
        toggle_ce = 1'b0;

        // Colour bars
        mode = 2'd1;
        wait_fs();
        chk("bar_x0", 32'(rgb), 32'hFFFFFF);
        wait_pixel(1, 0);  chk("bar_x1", 32'(rgb), 32'hFFFFFF);
        wait_pixel(4, 0);  chk("bar_x4", 32'(rgb), 32'h00FFFF);
        wait_pixel(14, 0); chk("bar_x14", 32'(rgb), 32'h000000);
        wait_pixel(15, 0); chk("bar_x15", 32'(rgb), 32'h000000);
        wait_pixel(20, 0); chk("bar_blank", {7'd0, de, rgb}, 32'd0);

        // Checkerboard, then a mid-frame mode switch
        mode = 2'd2;
        wait_fs();
        chk("chk_0_0", 32'(rgb), 32'hFFFFFF);
        wait_pixel(2, 0); chk("chk_2_0", 32'(rgb), 32'h000000);
        wait_pixel(2, 2); chk("chk_2_2", 32'(rgb), 32'hFFFFFF);
        mode = 2'd0; color = 24'hABCDEF;
        wait_pixel(3, 3); chk("chk_hold_3_3", 32'(rgb), 32'hFFFFFF);
        wait_fs();
        chk("solid_next_frame", 32'(rgb), 32'hABCDEF);

        // Moving box from a fresh reset
        @(negedge clk);
        rstn = 1'b0; mode = 2'd3; color = 24'h123456;
        @(negedge clk);
        rstn = 1'b1;
        wait_fs();
        chk("box_f0_0_0", 32'(rgb), 32'h123456);
        wait_pixel(3, 3); chk("box_f0_3_3", 32'(rgb), 32'h123456);
        wait_pixel(4, 3); chk("box_f0_4_3", 32'(rgb), 32'h000000);
        repeat (12) wait_fs();
        chk("box_f12_0_0", 32'(rgb), 32'h000000);
        wait_pixel(11, 0); chk("box_f12_11_0", 32'(rgb), 32'h000000);
        wait_pixel(12, 0); chk("box_f12_12_0", 32'(rgb), 32'h123456);
        wait_pixel(15, 3); chk("box_f12_15_3", 32'(rgb), 32'h123456);
        wait_fs();
        chk("box_f13_0_0", 32'(rgb), 32'h123456);
        wait_pixel(12, 0); chk("box_f13_12_0", 32'(rgb), 32'h000000);

        // Mid-line reset pulse
        wait_pixel(5, 2);
        rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_sync", {30'd0, hs, vs}, 32'd3);
        chk("mid_rst_de_rgb", {7'd0, de, rgb}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("mid_rst_restart", {23'd0, xo, yo, fs}, 32'd1);
        repeat (30) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
